// File: rtl/char_display_scanner_if.sv
// Display bus for the character scanner: text word and enable in,
// active-low anode/segment drive and frame-wrap pulse out.
interface char_display_scanner_if;
   logic        enable;
   logic [39:0] instruction;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   modport master (
      output enable, instruction,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  enable, instruction,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/char_display_scanner.sv
// Multiplexes an 8-character, 5-bit-coded text word onto a common-anode
// 8-digit 7-segment display, latching the word once per frame.
module char_display_scanner #(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLANK_CYC = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   char_display_scanner_if.slave bus
);
   localparam int unsigned      DIV_W     = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

   typedef enum logic {ST_OFF, ST_SCAN} state_t;

   state_t           state, state_next;
   logic [DIV_W-1:0] div, div_next;
   logic [2:0]       idx, idx_next;
   logic [39:0]      shadow, shadow_next;
   logic             frame_done_q, frame_done_next;
   logic [7:0]       an_q, an_next;
   logic [6:0]       seg_q, seg_next;
   logic [4:0]       chars [8];
   logic [4:0]       code;

   // Active-high {g,f,e,d,c,b,a} glyphs for the 5-bit letter codes.
   function automatic logic [6:0] decode(input logic [4:0] c);
      case (c)
         5'd1:    decode = 7'h77;
         5'd2:    decode = 7'h7C;
         5'd3:    decode = 7'h39;
         5'd4:    decode = 7'h5E;
         5'd5:    decode = 7'h79;
         5'd6:    decode = 7'h71;
         5'd7:    decode = 7'h3D;
         5'd8:    decode = 7'h76;
         5'd9:    decode = 7'h30;
         5'd10:   decode = 7'h1E;
         5'd11:   decode = 7'h75;
         5'd12:   decode = 7'h38;
         5'd13:   decode = 7'h37;
         5'd14:   decode = 7'h54;
         5'd15:   decode = 7'h3F;
         5'd16:   decode = 7'h73;
         5'd17:   decode = 7'h67;
         5'd18:   decode = 7'h50;
         5'd19:   decode = 7'h6D;
         5'd20:   decode = 7'h78;
         5'd21:   decode = 7'h3E;
         5'd22:   decode = 7'h1C;
         5'd23:   decode = 7'h2A;
         5'd24:   decode = 7'h76;
         5'd25:   decode = 7'h6E;
         5'd26:   decode = 7'h5B;
         5'd27:   decode = 7'h40;
         5'd28:   decode = 7'h08;
         default: decode = 7'h00;
      endcase
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_OFF;
         div          <= '0;
         idx          <= '0;
         shadow       <= '0;
         frame_done_q <= 1'b0;
         an_q         <= '1;
         seg_q        <= '1;
      end else begin
         state        <= state_next;
         div          <= div_next;
         idx          <= idx_next;
         shadow       <= shadow_next;
         frame_done_q <= frame_done_next;
         an_q         <= an_next;
         seg_q        <= seg_next;
      end
   end

   always_comb begin
      state_next      = state;
      div_next        = div;
      idx_next        = idx;
      shadow_next     = shadow;
      frame_done_next = 1'b0;
      case (state)
         ST_OFF: begin
            div_next = '0;
            idx_next = '0;
            if (bus.enable) begin
               state_next  = ST_SCAN;
               shadow_next = bus.instruction;
            end
         end
         ST_SCAN: begin
            // Disable wins over the slot tick, so an abandoned frame never pulses.
            if (!bus.enable) begin
               state_next = ST_OFF;
               div_next   = '0;
               idx_next   = '0;
            end else if (div == DIV_LAST) begin
               div_next = '0;
               idx_next = idx + 3'd1;
               if (idx == 3'd7) begin
                  shadow_next     = bus.instruction;
                  frame_done_next = 1'b1;
               end
            end else begin
               div_next = div + DIV_W'(1);
            end
         end
         default: state_next = ST_OFF;
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         chars[i] = shadow[39 - 5*i -: 5];
      end
      code     = chars[idx];
      an_next  = '1;
      seg_next = '1;
      if (state == ST_SCAN && div >= BLANK_END) begin
         an_next  = ~(8'h80 >> idx);
         seg_next = ~decode(code);
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = 1'b1;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_char_display_scanner.sv
// Randomized bench for char_display_scanner against a time-based model:
// elapsed cycles since enable determine slot, blanking and frame wraps.
module tb_char_display_scanner;
   localparam int unsigned SD    = 4;
   localparam int unsigned BC    = 1;
   localparam int unsigned FRAME = 8 * SD;
   localparam logic [6:0] P_TAB [32] = '{
      7'h00, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D,
      7'h76, 7'h30, 7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h3F,
      7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A,
      7'h76, 7'h6E, 7'h5B, 7'h40, 7'h08, 7'h00, 7'h00, 7'h00};

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   char_display_scanner_if bus ();

   char_display_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] char_of(input logic [39:0] w, input int unsigned i);
      logic [39:0] sh;
      sh = (w >> (5 * (7 - i))) & 40'h1F;
      return sh[4:0];
   endfunction

   // Model: on/off, cycles elapsed since enable, and the word on show this frame.
   bit          m_on;
   int unsigned m_t;
   logic [39:0] m_sh;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_fd;

   always @(posedge clock or posedge reset) begin
      int unsigned slot;
      if (reset) begin
         m_on  = 1'b0;
         m_t   = 0;
         m_sh  = '0;
         e_an  = 8'hFF;
         e_seg = 7'h7F;
         e_fd  = 1'b0;
      end else begin
         if (!m_on || (m_t % SD) < BC) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
         end else begin
            slot  = (m_t / SD) % 8;
            e_an  = ~(8'h80 >> slot);
            e_seg = ~P_TAB[char_of(m_sh, slot)];
         end
         e_fd = 1'b0;
         if (!m_on) begin
            if (bus.enable) begin
               m_on = 1'b1;
               m_t  = 0;
               m_sh = bus.instruction;
            end
         end else if (!bus.enable) begin
            m_on = 1'b0;
            m_t  = 0;
         end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
               m_sh = bus.instruction;
               e_fd = 1'b1;
            end
         end
      end
      #1;
      chk("an", bus.an, e_an);
      chk("seg", bus.seg, e_seg);
      chk("dp", bus.dp, 1'b1);
      chk("frame_done", bus.frame_done, e_fd);
      chk("an_onehot", ($countones(~bus.an) <= 1), 1'b1);
   end

   task automatic pulse_reset();
      #2 reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int codes [5];
      int unsigned r;
      codes = '{27, 28, 29, 31, 0};
      bus.enable      = 1'b1;
      bus.instruction = '0;
      repeat (3) @(negedge clock);
      bus.instruction = {5'd3, 5'd15, 5'd14, 5'd22, 5'd5, 5'd18, 5'd20, 5'd0};
      reset = 1'b0;
      repeat (3 * SD + 2) @(negedge clock);
      bus.instruction = {8{5'd1}};
      repeat (2 * FRAME) @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         bus.instruction = {5'(codes[i]), 35'($urandom)};
         repeat (FRAME + 2) @(negedge clock);
      end

      for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != 5 * SD + 1; k++) @(negedge clock);
      bus.enable = 1'b0;
      repeat (3) @(negedge clock);
      bus.instruction = {$urandom, 8'($urandom)};
      bus.enable = 1'b1;
      repeat (FRAME + 5) @(negedge clock);

      repeat (SD + 2) @(negedge clock);
      pulse_reset();
      repeat (FRAME) @(negedge clock);

      repeat (80) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            bus.instruction = {$urandom, 8'($urandom)};
            repeat ($urandom_range(1, 40)) @(negedge clock);
         end else if (r <= 7) begin
            bus.enable = ~bus.enable;
            repeat ($urandom_range(1, 20)) @(negedge clock);
         end else if (r == 8) begin
            pulse_reset();
            repeat ($urandom_range(1, 10)) @(negedge clock);
         end else begin
            bus.enable = 1'b1;
            repeat (FRAME) @(negedge clock);
         end
      end

      repeat (5) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
